// File: rtl/usb_ep_status_mp.sv
// usb_ep_status_mp: multi-port endpoint status RAM. The priority port is always served;
//   N_AUX aux ports share the remaining cycles in round-robin order.
// Latency: a request accepted in cycle 0 has its result register and valid strobe in cycle 3
//   (request -> stage 1 register -> RAM -> output register). One access per cycle in total.
// Backpressure: the priority port is never stalled. An aux port holds its request until its
//   s_ready_0 bit is 1. Any priority request drops every aux ready bit for that cycle.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   p_*_0                    priority request: addr, read, zero, write, din
//   p_dout_3, p_valid_3      priority result register and its one-cycle update strobe
//   s_*_0                    aux requests, port i at slice i (AW or DW bits wide)
//   s_ready_0                combinational one-hot grant
//   s_dout_3, s_valid_3      per-aux-port result registers and update strobes
// Optional: define USB_EP_STATUS_BITMASK_EN to add p_mask_0 / s_mask_0 per-bit write masks.
// A mask bit of 1 writes that bit.
module usb_ep_status_mp #(
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int N_AUX = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       p_addr_0,
  input  logic                p_read_0,
  input  logic                p_zero_0,
  input  logic                p_write_0,
  input  logic [DW-1:0]       p_din_0,
`ifdef USB_EP_STATUS_BITMASK_EN
  input  logic [DW-1:0]       p_mask_0,
  input  logic [N_AUX*DW-1:0] s_mask_0,
`endif
  output logic [DW-1:0]       p_dout_3,
  output logic                p_valid_3,
  input  logic [N_AUX*AW-1:0] s_addr_0,
  input  logic [N_AUX-1:0]    s_read_0,
  input  logic [N_AUX-1:0]    s_zero_0,
  input  logic [N_AUX-1:0]    s_write_0,
  input  logic [N_AUX*DW-1:0] s_din_0,
  output logic [N_AUX-1:0]    s_ready_0,
  output logic [N_AUX*DW-1:0] s_dout_3,
  output logic [N_AUX-1:0]    s_valid_3
);

  localparam int IW = (N_AUX > 1) ? $clog2(N_AUX) : 1;

  logic             p_req;
  logic [N_AUX-1:0] s_req;
  logic [IW-1:0]    rr_q, rr_d, win;
  logic             found, grant_vld;

  assign p_req = p_read_0 | p_zero_0 | p_write_0;
  assign s_req = s_read_0 | s_zero_0 | s_write_0;

  // First requesting aux port at or after rr_q, scanning circularly.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N_AUX; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_AUX) idx = idx - N_AUX;
      if (!found && s_req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign grant_vld = found & ~p_req & ~rst;

  always_comb begin
    s_ready_0 = '0;
    if (grant_vld) s_ready_0[win] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_vld) rr_d = (win == IW'(N_AUX - 1)) ? '0 : win + 1'b1;
  end

  // Stage 0: select the winning request.
  logic [AW-1:0] addr_d;
  logic [DW-1:0] din_d;
  logic          we_d, rd_d, zero_d, isp_d;
  logic [IW-1:0] src_d;
`ifdef USB_EP_STATUS_BITMASK_EN
  logic [DW-1:0] mask_d, mask1_q;
`endif

  always_comb begin
    addr_d = p_addr_0;
    din_d  = p_din_0;
    we_d   = p_write_0;
    rd_d   = p_read_0 | p_zero_0;
    zero_d = p_zero_0;
    isp_d  = 1'b1;
    src_d  = '0;
`ifdef USB_EP_STATUS_BITMASK_EN
    mask_d = p_mask_0;
`endif
    if (!p_req) begin
      addr_d = s_addr_0[win*AW +: AW];
      din_d  = s_din_0[win*DW +: DW];
      we_d   = grant_vld & s_write_0[win];
      rd_d   = grant_vld & (s_read_0[win] | s_zero_0[win]);
      zero_d = s_zero_0[win];
      isp_d  = 1'b0;
      src_d  = win;
`ifdef USB_EP_STATUS_BITMASK_EN
      mask_d = s_mask_0[win*DW +: DW];
`endif
    end
  end

  logic [AW-1:0] addr1_q;
  logic [DW-1:0] din1_q, ram_q, rdata;
  logic          we1_q, rd1_q, zero1_q, isp1_q;
  logic          rd2_q, zero2_q, isp2_q;
  logic [IW-1:0] src1_q, src2_q;
  logic [DW-1:0]       p_dout_q;
  logic                p_valid_q;
  logic [N_AUX*DW-1:0] s_dout_q;
  logic [N_AUX-1:0]    s_valid_q;

  // Data path registers need no reset; the control bits below qualify them.
  always_ff @(posedge clk) begin
    addr1_q <= addr_d;
    din1_q  <= din_d;
    isp1_q  <= isp_d;
    src1_q  <= src_d;
    isp2_q  <= isp1_q;
    src2_q  <= src1_q;
`ifdef USB_EP_STATUS_BITMASK_EN
    mask1_q <= mask_d;
`endif
  end

  assign rdata = zero2_q ? '0 : ram_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q      <= '0;
      we1_q     <= 1'b0;
      rd1_q     <= 1'b0;
      zero1_q   <= 1'b0;
      rd2_q     <= 1'b0;
      zero2_q   <= 1'b0;
      p_valid_q <= 1'b0;
      s_valid_q <= '0;
      p_dout_q  <= '0;
      s_dout_q  <= '0;
    end else begin
      rr_q      <= rr_d;
      we1_q     <= we_d;
      rd1_q     <= rd_d;
      zero1_q   <= zero_d;
      rd2_q     <= rd1_q;
      zero2_q   <= zero1_q;
      p_valid_q <= rd2_q & isp2_q;
      s_valid_q <= '0;
      if (rd2_q && isp2_q) p_dout_q <= rdata;
      if (rd2_q && !isp2_q) begin
        s_valid_q[src2_q]            <= 1'b1;
        s_dout_q[src2_q*DW +: DW]    <= rdata;
      end
    end
  end

  // Read-first RAM: a same-cycle write is seen by the following access, not this one.
  // The write is suppressed under reset so an in-flight write is cancelled.
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we1_q && !rst) begin
`ifdef USB_EP_STATUS_BITMASK_EN
      for (int b = 0; b < DW; b++)
        if (mask1_q[b]) mem[addr1_q][b] <= din1_q[b];
`else
      mem[addr1_q] <= din1_q;
`endif
    end
    ram_q <= mem[addr1_q];
  end

  // Outputs read as zero for the whole reset period, including its first cycle.
  assign p_dout_3  = rst ? '0 : p_dout_q;
  assign p_valid_3 = p_valid_q & ~rst;
  assign s_dout_3  = rst ? '0 : s_dout_q;
  assign s_valid_3 = rst ? '0 : s_valid_q;

endmodule
